// File: rtl/hamming_7_4_decoder_stream_if.sv
// Stream bundle for the Hamming(7,4) decoder: codeword in, data out.
// Optional out_syndrome under HAMMING_DEC_SYNDROME_OUT_EN.
interface hamming_7_4_decoder_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_msg;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_corrected;
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
  logic [2:0] out_syndrome;
`endif

  modport master (
    output in_valid,
    output in_msg,
    output out_ready,
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
    input  out_syndrome,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_corrected
  );

  modport slave (
    input  in_valid,
    input  in_msg,
    input  out_ready,
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
    output out_syndrome,
`endif
    output in_ready,
    output out_valid,
    output out_data,
    output out_corrected
  );
endinterface

// File: rtl/hamming_7_4_decoder_stream.sv
// Two-stage Hamming(7,4) stream decoder with saturating statistics.
// Optional syndrome output/histogram: HAMMING_DEC_SYNDROME_OUT_EN.
module hamming_7_4_decoder_stream #(
  parameter int P     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  hamming_7_4_decoder_stream_if.slave bus,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] corrected_count
);

  localparam int N = (1 << P) - 1;
  localparam int K = N - P;

  function automatic logic [P-1:0] syndrome(
    input logic [N-1:0] m
  );
    logic [P-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < P; b++) begin
        if (((i + 1) & (1 << b)) != 0) begin
          s[b] = s[b] ^ m[i];
        end
      end
    end
    return s;
  endfunction

  function automatic logic [K-1:0] extract(
    input logic [N-1:0] w
  );
    logic [K-1:0] d;
    int           k;
    d = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        d[k] = w[i];
        k++;
      end
    end
    return d;
  endfunction

  logic           s1_valid;
  logic [N-1:0]   s1_msg;
  logic [P-1:0]   s1_syn;
  logic           s2_valid;
  logic [K-1:0]   s2_data;
  logic           s2_corr;
  logic [P-1:0]   s2_syn;

  logic           s1_adv;
  logic           s2_adv;
  logic           out_xfer;
  logic [P-1:0]   syn_in;
  logic [N-1:0]   flip;
  logic [N-1:0]   fixed;
  logic [K-1:0]   fix_data;
  logic           fix_corr;

  // Ready chain: a stage moves when it is empty or its consumer moves.
  always_comb begin
    s2_adv   = !s2_valid || bus.out_ready;
    s1_adv   = !s1_valid || s2_adv;
    out_xfer = s2_valid && bus.out_ready;
    bus.in_ready = s1_adv || rst;
  end

  // Syndrome of the incoming word, then single-bit repair of S1.
  always_comb begin
    syn_in = syndrome(bus.in_msg);
    flip   = '0;
    for (int i = 0; i < N; i++) begin
      flip[i] = (s1_syn == P'(i + 1));
    end
    fixed    = s1_msg ^ flip;
    fix_data = extract(fixed);
    fix_corr = (s1_syn != '0);
  end

  // Stage 1: capture codeword and its syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_msg   <= '0;
      s1_syn   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_msg <= bus.in_msg;
        s1_syn <= syn_in;
      end
    end
  end

  // Stage 2: register corrected data; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_corr  <= 1'b0;
      s2_syn   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= fix_data;
        s2_corr <= fix_corr;
        s2_syn  <= s1_syn;
      end
    end
  end

  // Output ports straight from the S2 registers.
  always_comb begin
    bus.out_valid     = s2_valid;
    bus.out_data      = s2_data;
    bus.out_corrected = s2_corr;
  end

  // Saturating delivered-word and corrected-word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count      <= '0;
      corrected_count <= '0;
    end else if (out_xfer) begin
      if (word_count != '1) begin
        word_count <= word_count + CNT_W'(1);
      end
      if (s2_corr && corrected_count != '1) begin
        corrected_count <= corrected_count + CNT_W'(1);
      end
    end
  end

`ifdef HAMMING_DEC_SYNDROME_OUT_EN
  logic [CNT_W-1:0] err_pos_hist [N];

  // Expose the syndrome that travelled with the word.
  always_comb begin
    bus.out_syndrome = s2_syn;
  end

  // Per-position error histogram, saturating, debug only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        err_pos_hist[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (out_xfer && s2_syn == P'(i + 1)
            && err_pos_hist[i] != '1) begin
          err_pos_hist[i] <= err_pos_hist[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_syn;
  always_comb begin
    unused_syn = ^s2_syn;
  end
`endif

endmodule

// File: tb/tb_hamming_7_4_decoder_stream.sv
// Randomised self-checking bench for hamming_7_4_decoder_stream.
// Reference decodes by nearest-codeword search.
module tb_hamming_7_4_decoder_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_7_4_decoder_stream_if bus ();
  hamming_7_4_decoder_stream_if bus4 ();

  logic [15:0] wc16, cc16;
  logic [3:0]  wc4, cc4;

  hamming_7_4_decoder_stream #(.P(3), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .word_count      (wc16),
    .corrected_count (cc16)
  );

  hamming_7_4_decoder_stream #(.P(3), .CNT_W(4)) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus4),
    .word_count      (wc4),
    .corrected_count (cc4)
  );

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_msg    = bus.in_msg;
  assign bus4.out_ready = bus.out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic [2:0] s;
    int         acc;
  } exp_t;

  // Nearest codeword; every 7-bit word is within distance 1 of one.
  function automatic exp_t ref_decode(input logic [6:0] w);
    exp_t       e;
    logic [6:0] diff;
    e.d = 'x; e.c = 1'bx; e.s = 'x; e.acc = 0;
    for (int v = 0; v < 16; v++) begin
      diff = enc(4'(v)) ^ w;
      if (diff == 7'd0) begin
        e.d = 4'(v); e.c = 1'b0; e.s = 3'd0;
      end else if ($countones(diff) == 1) begin
        e.d = 4'(v); e.c = 1'b1;
        for (int b = 0; b < 7; b++)
          if (diff[b]) e.s = 3'(b + 1);
      end
    end
    return e;
  endfunction

  exp_t sb[$];
  logic lat_chk   = 1'b0;
  logic rdy_mode  = 1'b0;
  logic prev_hold = 1'b0;
  logic [4:0] prev_out;
  int m_wc16, m_cc16, m_wc4, m_cc4;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_hold = 1'b0;
      m_wc16 = 0; m_cc16 = 0; m_wc4 = 0; m_cc4 = 0;
    end else begin
      chk("word_count", wc16, m_wc16);
      chk("corrected_count", cc16, m_cc16);
      chk("word_count_sat", wc4, m_wc4);
      chk("corrected_count_sat", cc4, m_cc4);
      if (prev_hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_stable",
            {bus.out_corrected, bus.out_data}, prev_out);
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out actual=%0h expected=none",
                   bus.out_data);
        end else begin
          e = sb[0];
          chk("out_data", bus.out_data, e.d);
          chk("out_corrected", bus.out_corrected, e.c);
`ifdef HAMMING_DEC_SYNDROME_OUT_EN
          chk("out_syndrome", bus.out_syndrome, e.s);
`endif
          if (bus.out_ready) begin
            if (lat_chk) chk("latency", cyc - e.acc, 2);
            void'(sb.pop_front());
            if (m_wc16 < 65535) m_wc16++;
            if (m_wc4 < 15) m_wc4++;
            if (e.c && m_cc16 < 65535) m_cc16++;
            if (e.c && m_cc4 < 15) m_cc4++;
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_out  = {bus.out_corrected, bus.out_data};
      if (bus.in_valid && bus.in_ready) begin
        e = ref_decode(bus.in_msg);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  // Random sink readiness when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_word(input logic [6:0] m);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_msg   = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 expected=1");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t       e;
    logic [6:0] m;
    logic [3:0] w [4];
    int         n, r, b1, b2;

    bus.in_valid  = 1'b0;
    bus.in_msg    = '0;
    bus.out_ready = 1'b1;

    e = ref_decode(7'h54);
    chk("model_enc_b", enc(4'hB), 7'h55);
    chk("model_dec_54", {e.d, e.c, e.s}, {4'hB, 1'b1, 3'd1});
    e = ref_decode(7'h15);
    chk("model_dec_15", {e.d, e.c, e.s}, {4'hB, 1'b1, 3'd7});
    e = ref_decode(7'h55);
    chk("model_dec_55", {e.d, e.c, e.s}, {4'hB, 1'b0, 3'd0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_corr", bus.out_corrected, 0);
    chk("rst_word_count", wc16, 0);
    chk("rst_corr_count", cc16, 0);
    rst = 1'b0;

    lat_chk = 1'b1;
    for (int d = 0; d < 16; d++) drive_word(enc(4'(d)));
    drain();
    lat_chk = 1'b0;
    chk("clean_words", wc16, 16);
    chk("clean_corr", cc16, 0);
    chk("clean_words_sat", wc4, 15);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      m = 7'h55 ^ (7'd1 << i);
      drive_word(m);
    end
    drain();
    chk("single_words", wc16, 7);
    chk("single_corr", cc16, 7);

    do_reset();
    for (int i = 0; i < 4; i++) w[i] = 4'($urandom_range(0, 15));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    bus.in_msg = enc(w[0]);
    repeat (6) begin
      @(negedge clk);
      if (bus.in_ready) n++;
      @(posedge clk); #1;
      bus.in_msg = enc(w[n > 3 ? 3 : n]);
    end
    @(negedge clk);
    chk("bp_accepted", n, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive_word(enc(w[2]));
    drive_word(enc(w[3]));
    drain();
    chk("bp_words", wc16, 4);

    do_reset();
    rdy_mode = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      m  = enc(4'($urandom_range(0, 15)));
      r  = $urandom_range(0, 3);
      b1 = $urandom_range(0, 6);
      b2 = (b1 + $urandom_range(1, 6)) % 7;
      if (r >= 2) m[b1] = ~m[b1];
      if (r == 3) m[b2] = ~m[b2];
      drive_word(m);
    end
    rdy_mode = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("rand_words", wc16, 1000);
    chk("sat_words", wc4, 15);
    chk("sat_corr", cc4, 15);

    bus.out_ready = 1'b0;
    drive_word(enc(4'h3));
    drive_word(enc(4'hC));
    do_reset();
    @(negedge clk);
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_in_ready", bus.in_ready, 1);
    chk("mid_words", wc16, 0);
    chk("mid_corr", cc16, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    m = enc(4'h6) ^ 7'h08;
    drive_word(m);
    drain();
    chk("mid_after_words", wc16, 1);
    chk("mid_after_corr", cc16, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_7_4_decoder_stream.md
Name: hamming_7_4_decoder_stream

Overview:
- Downstream consumer of the Hamming(7,4) encoder's 7-bit codewords.
- Accepts one codeword per cycle over a valid/ready handshake, computes the syndrome, corrects any single-bit error, and emits the 4 data bits.
- Two-stage registered pipeline with full backpressure, plus saturating statistics counters.
- Sits between the channel/error-injection model and the data sink.

Parameters:
- P, 3, number of parity bits. Codeword is 2**P-1 = 7 bits; data is 2**P-P-1 = 4 bits. Only 3 is supported.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_msg holds a codeword
- in_ready  output  1  block can accept in_msg this cycle
- in_msg  input  7  codeword {D4,D3,D2,P3,D1,P2,P1}, bit6..bit0
- out_valid  output  1  out_data/out_corrected valid
- out_ready  input  1  sink accepts output this cycle
- out_data  output  4  decoded data {D4,D3,D2,D1}
- out_corrected  output  1  a bit was flipped for this word
- word_count  output  CNT_W  words delivered on the output, saturating
- corrected_count  output  CNT_W  delivered words with out_corrected=1, saturating

Behaviour:
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Syndrome, bit positions 1..7 = in_msg[0..6]:
  - s[0] = m0^m2^m4^m6
  - s[1] = m1^m2^m5^m6
  - s[2] = m3^m4^m5^m6
- Correction: s≠0 flips in_msg[s-1] (s is the 1-based error position). s=0 leaves the word unchanged.
- Decoded data is {m6,m5,m4,m2} of the corrected word; out_corrected = (s≠0).
- Stage 1 (S1):
  - On an input transfer, register in_msg and s, and set s1_valid.
  - Syndrome computation is combinational on in_msg.
- Stage 2 (S2):
  - Registers the corrected data and flag from S1; out_valid = s2_valid.
  - Correction is computed combinationally from the S1 registers.
- Ready chain:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - in_ready has no combinational path from in_valid.
- Latency: an input accepted in cycle N gives out_valid in cycle N+2 when out_ready stays high. Throughput is 1 word/cycle.
- Backpressure:
  - With out_ready low, S2 holds and S1 fills; in_ready drops only when both are full.
  - Held outputs stay stable until transferred.
- Counters:
  - word_count increments on each output transfer.
  - corrected_count increments on output transfers with out_corrected=1.
  - Both saturate at 2**CNT_W-1 and never wrap.
- Simultaneous S1→S2 advance and new input in the same cycle are both legal; no bubble is inserted.
- Reset:
  - s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_corrected=0, word_count=0, corrected_count=0.
  - in_ready=1 during and after reset (both stages empty).
  - Reset mid-stream discards in-flight words; they are not counted.
- Double-bit errors are miscorrected silently. This is inherent to (7,4) and not flagged.

Optional Feature:
- Macro: HAMMING_DEC_SYNDROME_OUT_EN.
- Defined:
  - Adds output port out_syndrome [2:0], carried through S2 alongside out_data and valid with out_valid. Reset value 0.
  - Adds a saturating counter err_pos_hist, 7 entries of CNT_W bits, as internal debug registers: entry s-1 increments on each output transfer with syndrome s.
- Undefined: no out_syndrome port and no histogram registers; all other behaviour identical.

Test Plan:
- Clean stream: data 0x0..0xF encoded and sent back-to-back, out_ready=1 → out_data 0x0..0xF in order, each 2 cycles after acceptance; out_corrected=0; word_count=16, corrected_count=0.
- Single-bit errors: data 0xB (codeword 0x55) with each bit 0..6 flipped in turn, e.g. in_msg=0x54 → out_data=0xB, out_corrected=1, syndrome 1; corrected_count=7 after 7 words.
- Backpressure: 4 words sent with out_ready held low → in_ready drops after 2 accepted; no loss or duplication; release out_ready → 4 words out in order.
- Random stall: random in_valid and out_ready over 1000 words → output sequence equals input sequence; out_data stable while out_valid && !out_ready.
- Saturation: CNT_W=4 with 20 corrupted words → word_count=15, corrected_count=15, no wrap.
- Reset mid-stream: rst asserted with both stages full → next cycle out_valid=0, in_ready=1, counters 0; the next word decodes correctly.
